// File: rtl/adpll_lock_pkg.sv
// Shared types and helpers for the ADPLL lock detector: state encoding,
// loss-counter width and a saturating absolute-value function.
package adpll_lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQ     = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_STALLED = 2'd3
    } lock_state_e;

    localparam int unsigned LOSS_CNT_W = 8;

    // Absolute value of a sign-extended 'width'-bit quantity; the most-negative
    // code saturates to the largest positive code instead of wrapping.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] value,
                                            input int unsigned        width);
        logic [31:0] max_pos;
        max_pos = (32'd1 << (width - 32'd1)) - 32'd1;
        if (value < 32'sd0) begin
            if (value == (-$signed(max_pos) - 32'sd1)) begin
                sat_abs = max_pos;
            end else begin
                sat_abs = 32'(-value);
            end
        end else begin
            sat_abs = 32'(value);
        end
    endfunction

endpackage

// File: rtl/adpll_lock_detector_edge_sync.sv
// Two-flop synchroniser for the divided clock followed by a registered
// rising-edge detector; the pulse appears 3 cycles after the input rises.
module edge_sync (
    input  logic fpga_clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pulse_q;

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/adpll_lock_detector.sv
// Lock monitor for one ring node: qualifies phase error on divided-clock
// edges and reports lock, lock loss and stall. Optional statistics outputs
// are enabled with the ADPLL_LOCK_STATS_EN macro.
module adpll_lock_detector
    import adpll_lock_pkg::*;
#(
    parameter int ERROR_WIDTH    = 5,
    parameter int DCO_CC_WIDTH   = 5,
    parameter int LOCK_THRESH    = 1,
    parameter int UNLOCK_THRESH  = 3,
    parameter int LOCK_COUNT     = 16,
    parameter int UNLOCK_COUNT   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           fpga_clk_i,
    input  logic                           reset_i,
    input  logic                           gen_div8_i,
    input  logic signed [ERROR_WIDTH-1:0]  error_i,
    input  logic signed [DCO_CC_WIDTH-1:0] dco_cc_i,
`ifdef ADPLL_LOCK_STATS_EN
    output logic signed [DCO_CC_WIDTH-1:0] cc_min_o,
    output logic signed [DCO_CC_WIDTH-1:0] cc_max_o,
    output logic [LOSS_CNT_W-1:0]          loss_cnt_o,
`endif
    output logic                           locked_o,
    output logic                           stalled_o,
    output logic                           lock_lost_o,
    output logic [1:0]                     state_o
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_COUNT - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    lock_state_e       state_q, state_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [BAD_W-1:0]  bad_cnt_q, bad_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              locked_q, locked_d;
    logic              stalled_q, stalled_d;
    logic              lock_lost_q, lock_lost_d;

    logic        edge_pulse_s;
    logic [31:0] abs_err_s;
    logic        good_edge_s;
    logic        bad_edge_s;
    logic        tmo_term_s;

    edge_sync u_edge_sync (
        .fpga_clk_i (fpga_clk_i),
        .reset_i    (reset_i),
        .async_i    (gen_div8_i),
        .pulse_o    (edge_pulse_s)
    );

    assign abs_err_s   = sat_abs(32'(error_i), ERROR_WIDTH);
    assign good_edge_s = (abs_err_s <= 32'(LOCK_THRESH));
    assign bad_edge_s  = (abs_err_s >  32'(UNLOCK_THRESH));
    assign tmo_term_s  = (tmo_cnt_q == TMO_LAST);

    // State, counter and output registers
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            good_cnt_q  <= {GOOD_W{1'b0}};
            bad_cnt_q   <= {BAD_W{1'b0}};
            tmo_cnt_q   <= {TMO_W{1'b0}};
            locked_q    <= 1'b0;
            stalled_q   <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            locked_q    <= locked_d;
            stalled_q   <= stalled_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    // Next-state logic; an edge pulse always takes priority over the timeout
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;

        if (edge_pulse_s) begin
            tmo_cnt_d = {TMO_W{1'b0}};
        end else if (tmo_term_s) begin
            tmo_cnt_d = tmo_cnt_q;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1'b1);
        end

        case (state_q)
            ST_IDLE, ST_STALLED: begin
                if (edge_pulse_s) begin
                    state_d    = ST_ACQ;
                    good_cnt_d = {GOOD_W{1'b0}};
                    bad_cnt_d  = {BAD_W{1'b0}};
                end else if (tmo_term_s && (state_q != ST_STALLED)) begin
                    state_d = ST_STALLED;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ACQ: begin
                if (edge_pulse_s) begin
                    if (!good_edge_s) begin
                        good_cnt_d = {GOOD_W{1'b0}};
                    end else if (good_cnt_q == GOOD_LAST) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = {GOOD_W{1'b0}};
                        bad_cnt_d  = {BAD_W{1'b0}};
                    end else begin
                        good_cnt_d = good_cnt_q + GOOD_W'(1'b1);
                    end
                end else if (tmo_term_s) begin
                    state_d    = ST_STALLED;
                    good_cnt_d = {GOOD_W{1'b0}};
                    bad_cnt_d  = {BAD_W{1'b0}};
                end else begin
                    state_d = ST_ACQ;
                end
            end
            ST_LOCKED: begin
                if (edge_pulse_s) begin
                    if (!bad_edge_s) begin
                        bad_cnt_d = {BAD_W{1'b0}};
                    end else if (bad_cnt_q == BAD_LAST) begin
                        state_d    = ST_ACQ;
                        good_cnt_d = {GOOD_W{1'b0}};
                        bad_cnt_d  = {BAD_W{1'b0}};
                    end else begin
                        bad_cnt_d = bad_cnt_q + BAD_W'(1'b1);
                    end
                end else if (tmo_term_s) begin
                    state_d    = ST_STALLED;
                    good_cnt_d = {GOOD_W{1'b0}};
                    bad_cnt_d  = {BAD_W{1'b0}};
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                good_cnt_d = {GOOD_W{1'b0}};
                bad_cnt_d  = {BAD_W{1'b0}};
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it
    always_comb begin
        locked_d    = (state_d == ST_LOCKED);
        stalled_d   = (state_d == ST_STALLED);
        lock_lost_d = (state_q == ST_LOCKED) && (state_d != ST_LOCKED);
    end

    assign locked_o    = locked_q;
    assign stalled_o   = stalled_q;
    assign lock_lost_o = lock_lost_q;
    assign state_o     = state_q;

`ifdef ADPLL_LOCK_STATS_EN
    logic signed [DCO_CC_WIDTH-1:0] cc_min_q, cc_min_d;
    logic signed [DCO_CC_WIDTH-1:0] cc_max_q, cc_max_d;
    logic [LOSS_CNT_W-1:0]          loss_cnt_q, loss_cnt_d;

    // Control-code extremes while locked and saturating lock-loss count
    always_comb begin
        cc_min_d   = cc_min_q;
        cc_max_d   = cc_max_q;
        loss_cnt_d = loss_cnt_q;
        if ((state_q != ST_LOCKED) && (state_d == ST_LOCKED)) begin
            cc_min_d = dco_cc_i;
            cc_max_d = dco_cc_i;
        end else if ((state_q == ST_LOCKED) && edge_pulse_s) begin
            cc_min_d = (dco_cc_i < cc_min_q) ? dco_cc_i : cc_min_q;
            cc_max_d = (dco_cc_i > cc_max_q) ? dco_cc_i : cc_max_q;
        end else begin
            cc_min_d = cc_min_q;
            cc_max_d = cc_max_q;
        end
        if (lock_lost_d && (loss_cnt_q != {LOSS_CNT_W{1'b1}})) begin
            loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1'b1);
        end else begin
            loss_cnt_d = loss_cnt_q;
        end
    end

    // Statistics registers
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            cc_min_q   <= {DCO_CC_WIDTH{1'b0}};
            cc_max_q   <= {DCO_CC_WIDTH{1'b0}};
            loss_cnt_q <= {LOSS_CNT_W{1'b0}};
        end else begin
            cc_min_q   <= cc_min_d;
            cc_max_q   <= cc_max_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign cc_min_o   = cc_min_q;
    assign cc_max_o   = cc_max_q;
    assign loss_cnt_o = loss_cnt_q;
`else
    logic unused_dco_cc_s;
    assign unused_dco_cc_s = ^dco_cc_i;
`endif

endmodule

// File: tb/tb_adpll_lock_detector.sv
// Scoreboard bench for adpll_lock_detector (default parameters); build with
// ADPLL_LOCK_STATS_EN to also cover the statistics outputs.
module tb_adpll_lock_detector;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              gen_i;
    logic signed [4:0] err_i;
    logic signed [4:0] cc_i;
    logic              locked_o;
    logic              stalled_o;
    logic              lock_lost_o;
    logic [1:0]        state_o;
`ifdef ADPLL_LOCK_STATS_EN
    logic signed [4:0] cc_min_o;
    logic signed [4:0] cc_max_o;
    logic [7:0]        loss_cnt_o;
`endif

    always #5 clk = ~clk;

    adpll_lock_detector dut (
        .fpga_clk_i  (clk),
        .reset_i     (reset_i),
        .gen_div8_i  (gen_i),
        .error_i     (err_i),
        .dco_cc_i    (cc_i),
`ifdef ADPLL_LOCK_STATS_EN
        .cc_min_o    (cc_min_o),
        .cc_max_o    (cc_max_o),
        .loss_cnt_o  (loss_cnt_o),
`endif
        .locked_o    (locked_o),
        .stalled_o   (stalled_o),
        .lock_lost_o (lock_lost_o),
        .state_o     (state_o)
    );

    typedef struct {
        int st;
        int lk;
        int stl;
        int lost;
        int cmin;
        int cmax;
        int loss;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_state, m_good, m_bad, m_min, m_max, m_loss;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_good = 0; m_bad = 0;
        m_min = 0; m_max = 0; m_loss = 0;
    endtask

    // Reference behaviour for one divided-clock edge with error e and code c
    task automatic model_edge(input int e, input int c);
        int   a;
        int   prev;
        int   lost;
        exp_t x;
        a    = (e == -16) ? 15 : ((e < 0) ? -e : e);
        prev = m_state;
        lost = 0;
        case (m_state)
            0, 3: begin m_state = 1; m_good = 0; m_bad = 0; end
            1: begin
                if (a <= 1) begin
                    m_good++;
                    if (m_good == 16) begin m_state = 2; m_good = 0; m_bad = 0; end
                end else begin
                    m_good = 0;
                end
            end
            default: begin
                if (a > 3) begin
                    m_bad++;
                    if (m_bad == 4) begin m_state = 1; m_good = 0; m_bad = 0; lost = 1; end
                end else begin
                    m_bad = 0;
                end
            end
        endcase
        if (prev != 2 && m_state == 2) begin
            m_min = c; m_max = c;
        end else if (prev == 2) begin
            if (c < m_min) m_min = c;
            if (c > m_max) m_max = c;
        end
        if (lost == 1 && m_loss < 255) m_loss++;
        x = '{m_state, (m_state == 2) ? 1 : 0, (m_state == 3) ? 1 : 0, lost, m_min, m_max, m_loss};
        sb_q.push_back(x);
    endtask

    task automatic check_outputs(input string tag, input exp_t x);
        check_val({tag, ".state"},   int'(state_o),     x.st);
        check_val({tag, ".locked"},  int'(locked_o),    x.lk);
        check_val({tag, ".stalled"}, int'(stalled_o),   x.stl);
        check_val({tag, ".lost"},    int'(lock_lost_o), x.lost);
`ifdef ADPLL_LOCK_STATS_EN
        check_val({tag, ".cc_min"},  int'(cc_min_o),    x.cmin);
        check_val({tag, ".cc_max"},  int'(cc_max_o),    x.cmax);
        check_val({tag, ".loss"},    int'(loss_cnt_o),  x.loss);
`endif
    endtask

    // One 16-cycle divided-clock period; result compared after the pulse lands
    task automatic drive_edge(input string tag, input int e, input int c);
        exp_t x;
        err_i = 5'(e);
        cc_i  = 5'(c);
        model_edge(e, c);
        gen_i = 1'b1;
        repeat (4) @(negedge clk);
        x = sb_q.pop_front();
        check_outputs(tag, x);
        @(negedge clk);
        check_val({tag, ".lost_width"}, int'(lock_lost_o), 0);
        repeat (3) @(negedge clk);
        gen_i = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic drive_n(input string tag, input int n, input int e, input int c);
        for (int i = 0; i < n; i++) drive_edge(tag, e, c);
    endtask

    initial begin
        exp_t x;
        int   cnt;
        reset_i = 1'b1;
        gen_i   = 1'b0;
        err_i   = 5'sd0;
        cc_i    = 5'sd0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        x = '{0, 0, 0, 0, 0, 0, 0};
        check_outputs("reset", x);

        // Acquire: first edge unevaluated, then 16 good edges
        drive_n("acq0", 17, 0, 0);
        // Over-threshold errors that do not reach the unlock count
        drive_n("lk_p4", 3, 4, 0);
        drive_edge("lk_zero", 0, 0);
        drive_n("lk_m4", 4, -4, 0);
        // Good count broken by a single |e|=2 edge on the 16th
        drive_n("acq_e1", 15, 1, 0);
        drive_edge("acq_e2", 2, 0);
        drive_n("acq_re", 16, 0, 0);
        // |e| equal to the unlock threshold is tolerated
        drive_n("lk_e3", 5, 3, 0);
        // Most-negative error saturates to 15 and counts as bad
        drive_n("lk_m16", 4, -16, 0);
        drive_edge("acq_m16", -16, 0);
        drive_n("acq_re2", 16, 0, 0);

        // Stall: hold the divided clock low while locked
        cnt = 0;
        while (stalled_o !== 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check_val("stall_delay", cnt, 1012);
        m_state = 3; m_good = 0; m_bad = 0;
        if (m_loss < 255) m_loss++;
        x = '{3, 0, 1, 1, m_min, m_max, m_loss};
        check_outputs("stall", x);
        @(negedge clk);
        check_val("stall.lost_width", int'(lock_lost_o), 0);
        drive_edge("unstall", 0, 0);

        // Relock and sweep the control code
        drive_n("acq_re3", 16, 0, 0);
        for (int c = -3; c <= 5; c++) drive_edge("sweep", 0, c);

        // Reset asserted in the middle of a sweep period
        err_i = 5'sd0;
        cc_i  = -5'sd2;
        gen_i = 1'b1;
        repeat (2) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        model_reset();
        x = '{0, 0, 0, 0, 0, 0, 0};
        check_outputs("midreset", x);
        reset_i = 1'b0;
        gen_i   = 1'b0;
        repeat (8) @(negedge clk);
        drive_edge("post_reset", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
